// File: rtl/pid_pkg.sv
// Shared definitions for the PID step scheduler: FSM encoding, MAC term
// indices and the accumulator sizing helper.
package pid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned IDX_W = 3;

    // Order in which the shared multiplier walks the difference equation
    localparam logic [IDX_W-1:0] IDX_B2 = 3'd0;
    localparam logic [IDX_W-1:0] IDX_B1 = 3'd1;
    localparam logic [IDX_W-1:0] IDX_B0 = 3'd2;
    localparam logic [IDX_W-1:0] IDX_A1 = 3'd3;
    localparam logic [IDX_W-1:0] IDX_A0 = 3'd4;

    // Five products of (adc+1)x(reg) bits plus sign headroom
    function automatic int unsigned acc_width(input int unsigned adc_w,
                                              input int unsigned reg_w);
        return adc_w + reg_w + 32'd4;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clock-enable pulses down to one control-step tick.
// Ports: i_clk, i_rst (async, active-high), i_clk_en (count enable),
//        o_tick_c (combinational, high for the wrap cycle only).
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 200000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clk_en,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap   = (r_count == CNT_LAST);
    assign o_tick_c = i_clk_en && w_wrap;

    // Free-running modulo-TICK_DIV counter gated by the enable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clk_en) begin
            r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pid_step_scheduler.sv
// Time-multiplexed IIR/PID controller: one step per prescaler tick, five
// MAC cycles on a single signed multiplier, then scale, saturate and publish.
// Ports: clk_i, rst_i (async, active-high), clk_en_i, clear_i,
//        ADC_value_i/SET_value_i (unsigned), b2_i..a0_i (signed Q2.FRAC),
//        PID_Val_o (signed), valid_o, busy_o, overrun_o.
module pid_step_scheduler
    import pid_pkg::*;
#(
    parameter int unsigned ADC_BITWIDTH  = 4,
    parameter int unsigned REG_BITWIDTH  = 8,
    parameter int unsigned FRAC_BITWIDTH = 6,
    parameter int unsigned TICK_DIV      = 200000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clk_en_i,
    input  logic                           clear_i,
    input  logic [ADC_BITWIDTH-1:0]        ADC_value_i,
    input  logic [ADC_BITWIDTH-1:0]        SET_value_i,
    input  logic signed [REG_BITWIDTH-1:0] b2_i,
    input  logic signed [REG_BITWIDTH-1:0] b1_i,
    input  logic signed [REG_BITWIDTH-1:0] b0_i,
    input  logic signed [REG_BITWIDTH-1:0] a1_i,
    input  logic signed [REG_BITWIDTH-1:0] a0_i,
    output logic signed [ADC_BITWIDTH:0]   PID_Val_o,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           overrun_o
);

    localparam int unsigned XW     = ADC_BITWIDTH + 1;
    localparam int unsigned PROD_W = XW + REG_BITWIDTH;
    localparam int unsigned ACC_W  = acc_width(ADC_BITWIDTH, REG_BITWIDTH);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** ADC_BITWIDTH) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2 ** ADC_BITWIDTH));

    state_t                   r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [XW-1:0]     r_x0, r_x1, r_x2, r_y1, r_y2, r_pid;
    logic                     r_valid, r_busy, r_overrun;
    logic                     w_valid_nxt, w_busy_nxt;
    logic                     w_tick;

    logic signed [REG_BITWIDTH-1:0] w_coef;
    logic signed [XW-1:0]           w_opnd;
    logic                           w_sub;
    logic signed [PROD_W-1:0]       w_prod;
    logic signed [ACC_W-1:0]        w_prod_ext, w_shift;
    logic signed [XW-1:0]           w_y;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clk_en (clk_en_i),
        .o_tick_c (w_tick)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and registered-output next values; clear always wins
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_tick) w_state_nxt = ST_MAC;
                ST_MAC:   if (r_idx == IDX_A0) w_state_nxt = ST_SCALE;
                ST_SCALE: begin
                    w_state_nxt = ST_DONE;
                    w_valid_nxt = 1'b1;
                end
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Operand select for the shared multiplier; feedback terms subtract
    always_comb begin
        w_coef = '0;
        w_opnd = '0;
        w_sub  = 1'b0;
        case (r_idx)
            IDX_B2: begin w_coef = b2_i; w_opnd = r_x0; end
            IDX_B1: begin w_coef = b1_i; w_opnd = r_x1; end
            IDX_B0: begin w_coef = b0_i; w_opnd = r_x2; end
            IDX_A1: begin w_coef = a1_i; w_opnd = r_y1; w_sub = 1'b1; end
            IDX_A0: begin w_coef = a0_i; w_opnd = r_y2; w_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_prod     = PROD_W'(w_coef) * PROD_W'(w_opnd);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_shift    = r_acc >>> FRAC_BITWIDTH;

    // Floor-scaled result clamped to the output range
    always_comb begin
        if (w_shift > Y_MAX)      w_y = XW'(Y_MAX);
        else if (w_shift < Y_MIN) w_y = XW'(Y_MIN);
        else                      w_y = XW'(w_shift);
    end

    // Datapath, history and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx     <= '0;
            r_acc     <= '0;
            r_x0      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_y1      <= '0;
            r_y2      <= '0;
            r_pid     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            if (clear_i) begin
                r_x1      <= '0;
                r_x2      <= '0;
                r_y1      <= '0;
                r_y2      <= '0;
                r_pid     <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
                case (r_state)
                    ST_IDLE: if (w_tick) begin
                        r_x0  <= XW'(SET_value_i) - XW'(ADC_value_i);
                        r_acc <= '0;
                        r_idx <= IDX_B2;
                    end
                    ST_MAC: begin
                        r_acc <= w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
                        r_idx <= r_idx + IDX_W'(1);
                    end
                    ST_SCALE: begin
                        r_pid <= w_y;
                        r_x2  <= r_x1;
                        r_x1  <= r_x0;
                        r_y2  <= r_y1;
                        r_y1  <= w_y;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign PID_Val_o = r_pid;
    assign valid_o   = r_valid;
    assign busy_o    = r_busy;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_pid_step_scheduler.sv
// Directed bench for pid_step_scheduler with TICK_DIV=8 and fixed
// coefficients b2=94, b1=0, b0=-93, a1=0, a0=-64.
module tb_pid_step_scheduler;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clk_en = 1'b1;
    logic                clear = 1'b0;
    logic [3:0]          adc_v = 4'd0;
    logic [3:0]          set_v = 4'd0;
    logic signed [7:0]   b2 = 8'sd94;
    logic signed [7:0]   b1 = 8'sd0;
    logic signed [7:0]   b0 = -8'sd93;
    logic signed [7:0]   a1 = 8'sd0;
    logic signed [7:0]   a0 = -8'sd64;
    logic signed [4:0]   pid;
    logic                valid, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    pid_step_scheduler #(
        .ADC_BITWIDTH(4), .REG_BITWIDTH(8), .FRAC_BITWIDTH(6), .TICK_DIV(8)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .clear_i(clear),
        .ADC_value_i(adc_v), .SET_value_i(set_v),
        .b2_i(b2), .b1_i(b1), .b0_i(b0), .a1_i(a1), .a0_i(a0),
        .PID_Val_o(pid), .valid_o(valid), .busy_o(busy), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for a negedge at which the next posedge is a tick edge
    task automatic wait_tick(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_dut.w_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s tick: got no tick in 40 cycles, required one", name);
        end
    endtask

    // Runs one step from its tick edge (e=0) to the edge back into IDLE (e=7)
    task automatic run_step(input string name, input bit have_tick,
                            input logic signed [4:0] exp_val,
                            input logic signed [15:0] exp_acc,
                            input bit glitch, input int force_e);
        bit ok;
        int lat;
        logic [3:0] s_set, s_adc;
        lat = -1;
        ok  = 1'b1;
        if (!have_tick) wait_tick(name, ok);
        if (!ok) return;
        s_set = set_v;
        s_adc = adc_v;
        for (int e = 0; e <= 7; e++) begin
            @(posedge clk);
            #1;
            if (glitch && e == 1) begin set_v = 4'd3; adc_v = 4'd12; end
            if (glitch && e == 5) begin set_v = s_set; adc_v = s_adc; end
            if (e == force_e - 1) force u_dut.w_tick = 1'b1;
            if (e == force_e) release u_dut.w_tick;
            if (e == 0) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_start: got %b, required 1", name, busy);
                end
            end
            if (valid === 1'b1 && lat < 0) begin
                lat = e;
                n_checks++;
                if (pid !== exp_val) begin
                    n_fail++;
                    $display("FAIL %s pid: got %0d, required %0d", name, pid, exp_val);
                end
                n_checks++;
                if (u_dut.r_acc !== exp_acc) begin
                    n_fail++;
                    $display("FAIL %s acc: got %0d, required %0d", name, u_dut.r_acc, exp_acc);
                end
            end
            if (e == 7) begin
                n_checks++;
                if (busy !== 1'b0 || valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s end_idle: got busy=%b valid=%b, required 0 0", name, busy, valid);
                end
            end
        end
        n_checks++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required 6", name, lat);
        end
    endtask

    // One-cycle clear; returns 1 ns after the clearing edge
    task automatic do_clear(input string name);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n_checks++;
        if (pid !== 5'sd0 || overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s clear: got pid=%0d ovr=%b busy=%b, required 0 0 0", name, pid, overrun, busy);
        end
    endtask

    // Counts negedges from reset release to the first visible tick
    task automatic check_first_tick(input string name);
        int n;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (u_dut.w_tick === 1'b1) begin
                n = i;
                break;
            end
        end
        n_checks++;
        if (n != 7) begin
            n_fail++;
            $display("FAIL %s first_tick: got negedge %0d, required 7", name, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pid !== 5'sd0 || valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got pid=%0d v=%b b=%b o=%b, required all 0", pid, valid, busy, overrun);
        end
    endtask

    task automatic test_first_step();
        set_v = 4'd8;
        adc_v = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        check_first_tick("first");
        run_step("first", 1'b1, 5'sd11, 16'sd752, 1'b0, -1);
    endtask

    task automatic test_history();
        run_step("hist2", 1'b0, 5'sd11, 16'sd752, 1'b1, -1);
        run_step("hist3", 1'b0, 5'sd11, 16'sd712, 1'b0, -1);
    endtask

    task automatic test_saturation();
        set_v = 4'd15;
        adc_v = 4'd0;
        do_clear("sat_pos");
        run_step("sat_pos", 1'b0, 5'sd15, 16'sd1410, 1'b0, -1);
        set_v = 4'd0;
        adc_v = 4'd15;
        do_clear("sat_neg");
        run_step("sat_neg", 1'b0, -5'sd16, -16'sd1410, 1'b0, -1);
    endtask

    task automatic test_overrun();
        set_v = 4'd8;
        adc_v = 4'd0;
        do_clear("ovr");
        run_step("ovr", 1'b0, 5'sd11, 16'sd752, 1'b0, 2);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr flag: got %b, required 1", overrun);
        end
        do_clear("ovr_clr");
    endtask

    task automatic test_reset_mid_step();
        bit ok;
        bit saw_valid;
        saw_valid = 1'b0;
        run_step("pre_rst", 1'b0, 5'sd11, 16'sd752, 1'b0, -1);
        wait_tick("mid_rst", ok);
        if (!ok) return;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (pid !== 5'sd0 || valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0
            || u_dut.r_acc !== 16'sd0) begin
            n_fail++;
            $display("FAIL mid_rst outputs: got pid=%0d v=%b b=%b o=%b acc=%0d, required all 0",
                     pid, valid, busy, overrun, u_dut.r_acc);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) begin
            n_fail++;
            $display("FAIL mid_rst valid: got a pulse, required none");
        end
        @(negedge clk);
        rst = 1'b0;
        check_first_tick("after_rst");
        run_step("after_rst", 1'b1, 5'sd11, 16'sd752, 1'b0, -1);
    endtask

    task automatic test_clear_tick();
        bit ok;
        bit bad;
        bad = 1'b0;
        wait_tick("clr_tick", ok);
        if (!ok) return;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || pid !== 5'sd0) begin
            n_fail++;
            $display("FAIL clr_tick edge: got busy=%b pid=%0d, required 0 0", busy, pid);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL clr_tick hold: got a step started, required none");
        end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_history();
        test_saturation();
        test_overrun();
        test_reset_mid_step();
        test_clear_tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
